// File: rtl/pcpi_mem_responder_pkg.sv
// Shared types and constants for the picorv32/coprocessor SRAM responder.
// Holds the FSM state enum, grant enum, default MMIO constants and address classifier.
package pcpi_mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_e;
  typedef enum logic {GNT_CPU, GNT_COP} grant_e;
  typedef enum logic [1:0] {IN_RANGE, CONSOLE, PASS, OOB} addr_class_e;

  localparam logic [31:0] DEF_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEF_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEF_PASS_MAGIC   = 32'd123456789;

  // SRAM range wins over MMIO; range compare uses the full word address.
  function automatic addr_class_e addr_class(
    input logic [31:0] addr,
    input logic [31:0] mem_words,
    input logic [31:0] console_addr,
    input logic [31:0] pass_addr
  );
    addr_class_e cls;
    if ((addr >> 2) < mem_words)   cls = IN_RANGE;
    else if (addr == console_addr) cls = CONSOLE;
    else if (addr == pass_addr)    cls = PASS;
    else                           cls = OOB;
    return cls;
  endfunction

endpackage

// File: rtl/pcpi_mem_responder_arb.sv
// rr_arb2: two-requester round-robin arbiter; last_grant only moves on a conflict,
// so after reset (last_grant = COP) the CPU wins the first conflict.
module rr_arb2
  import pcpi_mem_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_en,
  input  logic   i_req_cpu,
  input  logic   i_req_cop,
  output grant_e o_gnt_c,
  output logic   o_any_c
);

  grant_e r_last;
  logic   w_both;

  assign w_both  = i_req_cpu & i_req_cop;
  assign o_any_c = i_req_cpu | i_req_cop;

  always_comb begin
    o_gnt_c = GNT_CPU;
    if (w_both)         o_gnt_c = (r_last == GNT_COP) ? GNT_CPU : GNT_COP;
    else if (i_req_cop) o_gnt_c = GNT_COP;
  end

  always_ff @(posedge clk) begin
    if (reset)                r_last <= GNT_COP;
    else if (i_en && w_both)  r_last <= o_gnt_c;
  end

endmodule

// File: rtl/pcpi_mem_responder.sv
// pcpi_mem_responder: shares one word SRAM between picorv32 and the KNN coprocessor,
// with console/pass MMIO and OOB trapping. Define PCPI_MEM_STATS_EN for grant/conflict counters.
module pcpi_mem_responder
  import pcpi_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = 3145728,
  parameter logic [31:0] CONSOLE_ADDR = DEF_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_MAGIC   = DEF_PASS_MAGIC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_valid,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  input  logic [3:0]                    cpu_wstrb,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_ready,
  input  logic                          cop_valid,
  input  logic                          cop_write,
  input  logic [31:0]                   cop_addr,
  input  logic [31:0]                   cop_wdata,
  output logic [31:0]                   cop_rdata,
  output logic                          cop_ready,
  output logic                          sram_en,
  output logic [3:0]                    sram_we,
  output logic [$clog2(MEM_WORDS)-1:0]  sram_addr,
  output logic [31:0]                   sram_wdata,
  input  logic [31:0]                   sram_rdata,
  output logic                          console_valid,
  output logic [7:0]                    console_data,
  output logic                          tests_passed,
  output logic                          oob_err,
  output logic [31:0]                   oob_addr
`ifdef PCPI_MEM_STATS_EN
  ,
  output logic [31:0]                   stat_cpu_grants,
  output logic [31:0]                   stat_cop_grants,
  output logic [31:0]                   stat_conflicts
`endif
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  state_e      r_state;
  grant_e      r_gnt;
  grant_e      w_gnt;
  logic        w_any;
  logic        w_idle;
  logic        w_cpu_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_we;
  addr_class_e w_cls;

  assign w_idle = (r_state == ST_IDLE);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_en      (w_idle),
    .i_req_cpu (cpu_valid),
    .i_req_cop (cop_valid),
    .o_gnt_c   (w_gnt),
    .o_any_c   (w_any)
  );

  // Mux the granted requester's payload.
  always_comb begin
    w_addr  = cpu_addr;
    w_wdata = cpu_wdata;
    w_we    = cpu_wstrb;
    if (w_gnt == GNT_COP) begin
      w_addr  = cop_addr;
      w_wdata = cop_wdata;
      w_we    = cop_write ? 4'hF : 4'h0;
    end
  end

  assign w_cpu_wr = (w_gnt == GNT_CPU) && (cpu_wstrb != 4'h0);
  assign w_cls    = addr_class(w_addr, MEM_WORDS, CONSOLE_ADDR, PASS_ADDR);

  // IDLE -> ISSUE -> WAIT -> DONE for SRAM; IDLE -> DONE for MMIO/OOB.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_gnt         <= GNT_CPU;
      cpu_rdata     <= '0;
      cpu_ready     <= 1'b0;
      cop_rdata     <= '0;
      cop_ready     <= 1'b0;
      sram_en       <= 1'b0;
      sram_we       <= '0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      console_valid <= 1'b0;
      console_data  <= '0;
      tests_passed  <= 1'b0;
      oob_err       <= 1'b0;
      oob_addr      <= '0;
    end else begin
      cpu_ready     <= 1'b0;
      cop_ready     <= 1'b0;
      console_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt <= w_gnt;
            if (w_cls == IN_RANGE) begin
              sram_en    <= 1'b1;
              sram_we    <= w_we;
              sram_addr  <= AW'(w_addr >> 2);
              sram_wdata <= w_wdata;
              r_state    <= ST_ISSUE;
            end else begin
              if (w_gnt == GNT_CPU) begin
                cpu_ready <= 1'b1;
                cpu_rdata <= '0;
              end else begin
                cop_ready <= 1'b1;
                cop_rdata <= '0;
              end
              if (w_cpu_wr && w_cls == CONSOLE) begin
                console_valid <= 1'b1;
                console_data  <= w_wdata[7:0];
              end else if (w_cpu_wr && w_cls == PASS) begin
                if (w_wdata == PASS_MAGIC) tests_passed <= 1'b1;
              end else begin
                oob_err <= 1'b1;
                if (!oob_err) oob_addr <= w_addr;
              end
              r_state <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          sram_en <= 1'b0;
          sram_we <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_gnt == GNT_CPU) begin
            cpu_rdata <= sram_rdata;
            cpu_ready <= 1'b1;
          end else begin
            cop_rdata <= sram_rdata;
            cop_ready <= 1'b1;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PCPI_MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_grants <= '0;
      stat_cop_grants <= '0;
      stat_conflicts  <= '0;
    end else if (w_idle && w_any) begin
      if (w_gnt == GNT_CPU) stat_cpu_grants <= stat_cpu_grants + 32'd1;
      else                  stat_cop_grants <= stat_cop_grants + 32'd1;
      if (cpu_valid && cop_valid) stat_conflicts <= stat_conflicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcpi_mem_responder.sv
// Testbench for pcpi_mem_responder: SRAM environment model plus a word-level reference memory
// and round-robin model; randomized transactions checked against expected latency and data.
`timescale 1ns/1ps
module tb_pcpi_mem_responder;

  localparam int unsigned MEM_WORDS = 3145728;
  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam int unsigned OW        = 32+1+32+1+1+4+AW+32+1+8+1+1+32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_valid = 1'b0, cop_valid = 1'b0, cop_write = 1'b0;
  logic [31:0]   cpu_addr = '0, cpu_wdata = '0, cop_addr = '0, cop_wdata = '0;
  logic [3:0]    cpu_wstrb = '0;
  logic [31:0]   cpu_rdata, cop_rdata, sram_wdata, oob_addr;
  logic          cpu_ready, cop_ready, sram_en, console_valid, tests_passed, oob_err;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata = '0;
  logic [7:0]    console_data;
`ifdef PCPI_MEM_STATS_EN
  logic [31:0]   stat_cpu_grants, stat_cop_grants, stat_conflicts;
`endif

  pcpi_mem_responder dut (
    .clk(clk), .reset(reset),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cop_valid(cop_valid), .cop_write(cop_write), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
    .cop_rdata(cop_rdata), .cop_ready(cop_ready),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .console_valid(console_valid), .console_data(console_data),
    .tests_passed(tests_passed), .oob_err(oob_err), .oob_addr(oob_addr)
`ifdef PCPI_MEM_STATS_EN
    , .stat_cpu_grants(stat_cpu_grants), .stat_cop_grants(stat_cop_grants),
    .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  logic [OW-1:0] all_outs;
  assign all_outs = {cpu_rdata, cpu_ready, cop_rdata, cop_ready, sram_en, sram_we, sram_addr,
                     sram_wdata, console_valid, console_data, tests_passed, oob_err, oob_addr};

  int n_cmp = 0;
  int n_err = 0;

  // SRAM environment: registered read one cycle after sram_en, read-first on writes.
  logic [31:0] sram_mem [int unsigned];
  always @(posedge clk) begin
    logic [31:0] t;
    int unsigned k;
    if (sram_en) begin
      k = 32'(sram_addr);
      t = sram_mem.exists(k) ? sram_mem[k] : 32'h0;
      sram_rdata <= t;
      for (int b = 0; b < 4; b++) if (sram_we[b]) t[8*b +: 8] = sram_wdata[8*b +: 8];
      if (sram_we != 4'h0) sram_mem[k] = t;
    end
  end

  // Monitors sampled mid-cycle.
  int         cpu_rdy_cnt = 0, cop_rdy_cnt = 0, en_cnt = 0, con_cnt = 0;
  logic [7:0] con_last = '0;
  logic [3:0] last_we = '0;
  logic [AW-1:0] last_sa = '0;
  int         order_q [$];
  always @(negedge clk) begin
    if (cpu_ready) begin cpu_rdy_cnt++; order_q.push_back(0); end
    if (cop_ready) begin cop_rdy_cnt++; order_q.push_back(1); end
    if (sram_en) begin en_cnt++; last_we = sram_we; last_sa = sram_addr; end
    if (console_valid) begin con_cnt++; con_last = console_data; end
  end

  // Reference model: word memory and round-robin pointer (1 = COP was last conflict winner).
  logic [31:0] ref_mem [int unsigned];
  bit          model_last_cop = 1'b1;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int unsigned w = a >> 2;
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic void ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    if (s != 4'h0) ref_mem[a >> 2] = v;
  endfunction

  // Drivers: latency counts rising edges from request until ready is seen; -1 on timeout.
  task automatic cpu_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wstrb = s; cpu_valid = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!cpu_ready && lat < 20);
    rd = cpu_rdata;
    if (!cpu_ready) lat = -1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
  endtask

  task automatic cop_txn(input logic [31:0] a, input logic [31:0] d, input logic w,
                         output logic [31:0] rd, output int lat);
    @(negedge clk);
    cop_addr = a; cop_wdata = d; cop_write = w; cop_valid = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!cop_ready && lat < 20);
    rd = cop_rdata;
    if (!cop_ready) lat = -1;
    @(posedge clk); #1;
    cop_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL reset_outs: got %h required 0", all_outs); end
    reset = 1'b0;
    model_last_cop = 1'b1;
  endtask

  task automatic test_cpu_read();
    logic [31:0] rd; int lat;
    en_cnt = 0;
    cpu_txn(32'h14, 32'h0, 4'h0, rd, lat);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cpu_read_lat: got %0d required 3", lat); end
    n_cmp++; if (rd !== ref_rd(32'h14)) begin n_err++; $display("FAIL cpu_read_data: got %h required %h", rd, ref_rd(32'h14)); end
    n_cmp++; if (en_cnt !== 1) begin n_err++; $display("FAIL cpu_read_en_cycles: got %0d required 1", en_cnt); end
  endtask

  task automatic test_cpu_write();
    logic [31:0] rd; int lat;
    cpu_txn(32'h14, 32'h1122_3344, 4'b0101, rd, lat);
    ref_wr(32'h14, 32'h1122_3344, 4'b0101);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cpu_write_lat: got %0d required 3", lat); end
    n_cmp++; if (last_we !== 4'b0101) begin n_err++; $display("FAIL cpu_write_we: got %b required 0101", last_we); end
    n_cmp++; if (last_sa !== AW'(5)) begin n_err++; $display("FAIL cpu_write_sram_addr: got %0d required 5", last_sa); end
    cpu_txn(32'h14, 32'h0, 4'h0, rd, lat);
    n_cmp++; if (rd !== ref_rd(32'h14)) begin n_err++; $display("FAIL cpu_write_readback: got %h required %h", rd, ref_rd(32'h14)); end
  endtask

  // Both valids rise together; CPU window words 64..95, COP window 96..127.
  task automatic test_conflict(input int reps);
    for (int r = 0; r < reps; r++) begin
      logic [31:0] ca, oa, cd, od, crd, ord, cexp, oexp;
      logic [3:0]  cs;
      logic        ow;
      int          cl, ol, c0, o0, first;
      bit          cpu_first;
      ca = (32'd64 + 32'($urandom_range(0, 31))) * 4 + 32'($urandom_range(0, 3));
      oa = (32'd96 + 32'($urandom_range(0, 31))) * 4 + 32'($urandom_range(0, 3));
      cs = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      ow = 1'($urandom);
      cd = $urandom; od = $urandom;
      cexp = ref_rd(ca); oexp = ref_rd(oa);
      cpu_first = model_last_cop;
      model_last_cop = !cpu_first;
      c0 = cpu_rdy_cnt; o0 = cop_rdy_cnt;
      order_q.delete();
      fork
        cpu_txn(ca, cd, cs, crd, cl);
        cop_txn(oa, od, ow, ord, ol);
      join
      ref_wr(ca, cd, cs);
      ref_wr(oa, od, ow ? 4'hF : 4'h0);
      first = (order_q.size() > 0) ? order_q[0] : -1;
      n_cmp++; if (first !== (cpu_first ? 0 : 1)) begin n_err++; $display("FAIL conflict_winner[%0d]: got %0d required %0d (0=CPU 1=COP)", r, first, cpu_first ? 0 : 1); end
      n_cmp++; if (cl !== (cpu_first ? 3 : 7)) begin n_err++; $display("FAIL conflict_cpu_lat[%0d]: got %0d required %0d", r, cl, cpu_first ? 3 : 7); end
      n_cmp++; if (ol !== (cpu_first ? 7 : 3)) begin n_err++; $display("FAIL conflict_cop_lat[%0d]: got %0d required %0d", r, ol, cpu_first ? 7 : 3); end
      n_cmp++; if ((cpu_rdy_cnt - c0) !== 1 || (cop_rdy_cnt - o0) !== 1) begin n_err++; $display("FAIL conflict_ready_count[%0d]: got cpu %0d cop %0d required 1 each", r, cpu_rdy_cnt - c0, cop_rdy_cnt - o0); end
      if (cs == 4'h0) begin
        n_cmp++; if (crd !== cexp) begin n_err++; $display("FAIL conflict_cpu_data[%0d]: got %h required %h", r, crd, cexp); end
      end
      if (!ow) begin
        n_cmp++; if (ord !== oexp) begin n_err++; $display("FAIL conflict_cop_data[%0d]: got %h required %h", r, ord, oexp); end
      end
    end
  endtask

  task automatic test_cop_rw();
    logic [31:0] rd, crd; int lat;
    cpu_txn(32'h14, 32'h0, 4'h0, crd, lat);
    cop_txn(32'h0001_0000, 32'h7, 1'b1, rd, lat);
    ref_wr(32'h0001_0000, 32'h7, 4'hF);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL cop_write_lat: got %0d required 3", lat); end
    cop_txn(32'h0001_0000, 32'h0, 1'b0, rd, lat);
    n_cmp++; if (rd !== 32'h7) begin n_err++; $display("FAIL cop_readback: got %h required 00000007", rd); end
    n_cmp++; if (cpu_rdata !== ref_rd(32'h14)) begin n_err++; $display("FAIL cpu_rdata_hold: got %h required %h", cpu_rdata, ref_rd(32'h14)); end
  endtask

  task automatic test_mmio();
    logic [31:0] rd; int lat, c0;
    c0 = con_cnt;
    cpu_txn(32'h1000_0000, 32'h0000_0041, 4'h1, rd, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL console_lat: got %0d required 1", lat); end
    n_cmp++; if ((con_cnt - c0) !== 1 || con_last !== 8'h41) begin n_err++; $display("FAIL console_pulse: got %0d pulses data %h required 1 pulse data 41", con_cnt - c0, con_last); end
    cpu_txn(32'h2000_0000, 32'd123456788, 4'hF, rd, lat);
    n_cmp++; if (tests_passed !== 1'b0) begin n_err++; $display("FAIL pass_wrong_magic: got %b required 0", tests_passed); end
    cpu_txn(32'h2000_0000, 32'd123456789, 4'hF, rd, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL pass_lat: got %0d required 1", lat); end
    n_cmp++; if (tests_passed !== 1'b1) begin n_err++; $display("FAIL pass_flag: got %b required 1", tests_passed); end
    n_cmp++; if (oob_err !== 1'b0) begin n_err++; $display("FAIL mmio_no_oob: got %b required 0", oob_err); end
  endtask

  task automatic test_oob_reset();
    logic [31:0] rd, d; int lat, c0, o0;
    cop_txn(32'h0300_0000, 32'h0, 1'b0, rd, lat);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL oob_lat: got %0d required 1", lat); end
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL oob_rdata: got %h required 0", rd); end
    n_cmp++; if (oob_err !== 1'b1 || oob_addr !== 32'h0300_0000) begin n_err++; $display("FAIL oob_flag: got err %b addr %h required err 1 addr 03000000", oob_err, oob_addr); end
    cop_txn(MEM_WORDS * 4, 32'h0, 1'b0, rd, lat);
    n_cmp++; if (lat !== 1 || oob_addr !== 32'h0300_0000) begin n_err++; $display("FAIL oob_edge_word: got lat %0d addr %h required lat 1 addr 03000000", lat, oob_addr); end
    d = $urandom;
    cop_txn((MEM_WORDS - 1) * 4 + 3, d, 1'b1, rd, lat);
    ref_wr((MEM_WORDS - 1) * 4, d, 4'hF);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL last_word_lat: got %0d required 3", lat); end
    cop_txn((MEM_WORDS - 1) * 4, 32'h0, 1'b0, rd, lat);
    n_cmp++; if (rd !== ref_rd((MEM_WORDS - 1) * 4)) begin n_err++; $display("FAIL last_word_data: got %h required %h", rd, ref_rd((MEM_WORDS - 1) * 4)); end
    cpu_txn(32'h1000_0000, 32'h0, 4'h0, rd, lat);
    n_cmp++; if (lat !== 1 || rd !== 32'h0 || oob_addr !== 32'h0300_0000) begin n_err++; $display("FAIL cpu_console_read: got lat %0d rdata %h addr %h required 1 0 03000000", lat, rd, oob_addr); end
    // Reset lands on the ISSUE cycle of an in-range read.
    c0 = cpu_rdy_cnt; o0 = cop_rdy_cnt;
    @(negedge clk);
    cpu_addr = 32'h14; cpu_wstrb = 4'h0; cpu_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (sram_en !== 1'b1) begin n_err++; $display("FAIL issue_en: got %b required 1", sram_en); end
    reset = 1'b1; cpu_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (all_outs !== '0) begin n_err++; $display("FAIL midop_reset_outs: got %h required 0", all_outs); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_last_cop = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_cmp++; if (cpu_rdy_cnt !== c0 || cop_rdy_cnt !== o0 || all_outs !== '0) begin n_err++; $display("FAIL midop_no_ready: got cpu %0d cop %0d readies outs %h required none and 0", cpu_rdy_cnt - c0, cop_rdy_cnt - o0, all_outs); end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a, d, rd, exp;
      logic [3:0]  s;
      int          lat;
      bit          use_cop;
      a = (32'd64 + 32'($urandom_range(0, 63))) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      use_cop = 1'($urandom);
      s = ($urandom_range(0, 1) == 1) ? (use_cop ? 4'hF : 4'($urandom)) : 4'h0;
      exp = ref_rd(a);
      if (use_cop) cop_txn(a, d, s != 4'h0, rd, lat);
      else         cpu_txn(a, d, s, rd, lat);
      ref_wr(a, d, s);
      n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL rand_lat[%0d]: got %0d required 3", i, lat); end
      if (s == 4'h0) begin
        n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL rand_data[%0d]: got %h required %h addr %h", i, rd, exp, a); end
      end
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sram_mem[5] = 32'hDEAD_BEEF;
    ref_mem[5]  = 32'hDEAD_BEEF;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_conflict(4);
    test_cop_rw();
    test_mmio();
    test_oob_reset();
    test_random(30);
    test_conflict(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
